mux_arb: RTL

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux_arb.sv
// Two-requester arbiter with a registered 2:1 data path: ties alternate, and the grant is held while the request stays high.
// Define MUX_ARB_HOLD_LIMIT_EN to force a handover after HOLD_MAX consecutive grant cycles when the other side waits.
module mux_arb #(
    parameter int W        = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         gnt0,
    output logic         gnt1,
    output logic         Sel,
    output logic [W-1:0] Y,
    output logic         Y_vld
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   at_limit;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt;

    assign at_limit = (hold_cnt == HOLD_LAST);
`else
    // Without the hold limit HOLD_MAX has no effect, so the limit never fires.
    assign at_limit = (HOLD_MAX < 0);
`endif

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? GNT0 : GNT1;
                else if (req0)
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!req0)
                    state_nxt = req1 ? GNT1 : IDLE;
                else if (at_limit && req1)
                    state_nxt = GNT1;
            end
            GNT1: begin
                if (!req1)
                    state_nxt = req0 ? GNT0 : IDLE;
                else if (at_limit && req0)
                    state_nxt = GNT0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            Sel   <= 1'b0;
            Y     <= '0;
            Y_vld <= 1'b0;
            last  <= 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt0  <= (state_nxt == GNT0);
            gnt1  <= (state_nxt == GNT1);

            // Sel and last only move when a grant is active; IDLE keeps both.
            if (state_nxt == GNT0) begin
                Sel  <= 1'b0;
                last <= 1'b0;
            end else if (state_nxt == GNT1) begin
                Sel  <= 1'b1;
                last <= 1'b1;
            end

            // Data follows the grant that was active during the cycle just ended.
            if (state == GNT0) begin
                Y     <= A;
                Y_vld <= 1'b1;
            end else if (state == GNT1) begin
                Y     <= B;
                Y_vld <= 1'b1;
            end else begin
                Y_vld <= 1'b0;
            end

`ifdef MUX_ARB_HOLD_LIMIT_EN
            if (state_nxt != state)
                hold_cnt <= '0;
            else if (state != IDLE && !at_limit)
                hold_cnt <= hold_cnt + 8'd1;
`endif
        end
    end

endmodule
